// File: rtl/wordle_pkg.sv
// Shared letter/state definitions for the word entry stage and its helpers.
package wordle_pkg;

  localparam logic [4:0] LETTER_BLANK  = 5'd0;
  localparam logic [4:0] LETTER_A      = 5'd1;
  localparam int         ALPHA_MAX_DEF = 26;

  typedef logic [4:0] letter_t;

  typedef enum logic [0:0] {
    ST_EDIT   = 1'b0,
    ST_SUBMIT = 1'b1
  } entry_state_t;

endpackage

// File: rtl/word_entry_stage_if.sv
// Submit handshake and word bus between the entry stage and the game-logic checker.
interface word_entry_stage_if #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 5
);

  logic                         submit_valid_o;
  logic                         submit_ready_i;
  logic [WORD_LEN*LETTER_W-1:0] word_o;

  modport master (
    output submit_valid_o,
    output word_o,
    input  submit_ready_i
  );

  modport slave (
    input  submit_valid_o,
    input  word_o,
    output submit_ready_i
  );

endinterface

// File: rtl/word_entry_stage_checker.sv
// Invariants of the entry stage: letters stay legal, a submitted word is complete, cursor in range.
module word_entry_stage_checker #(
  parameter int WORD_LEN  = 5,
  parameter int LETTER_W  = 5,
  parameter int ALPHA_MAX = 26
) (
  input logic                         clk,
  input logic                         rst_n,
  input logic                         valid,
  input logic [WORD_LEN*LETTER_W-1:0] word,
  input logic [$clog2(WORD_LEN)-1:0]  cursor
);

  localparam int                  CW       = $clog2(WORD_LEN);
  localparam logic [CW-1:0]       LAST_COL = CW'(WORD_LEN - 1);
  localparam logic [LETTER_W-1:0] MAX_L    = LETTER_W'(ALPHA_MAX);

  logic [WORD_LEN-1:0] nonblank_s;

  // One flag per column marking a filled letter.
  always_comb begin
    nonblank_s = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      nonblank_s[i] = |word[i*LETTER_W +: LETTER_W];
    end
  end

  for (genvar g = 0; g < WORD_LEN; g++) begin : g_letter
    a_letter_legal: assert property (@(posedge clk) disable iff (!rst_n)
      word[g*LETTER_W +: LETTER_W] <= MAX_L);
  end

  a_valid_full: assert property (@(posedge clk) disable iff (!rst_n)
    valid |-> (&nonblank_s));

  a_cursor_range: assert property (@(posedge clk) disable iff (!rst_n)
    cursor <= LAST_COL);

endmodule

// File: rtl/word_entry_stage_letter_cycler.sv
// Next-letter values for inc/dec with wrap-around; a blank column enters the alphabet at either end.
module word_entry_stage_letter_cycler
  import wordle_pkg::*;
#(
  parameter int LETTER_W  = 5,
  parameter int ALPHA_MAX = ALPHA_MAX_DEF
) (
  input  logic [LETTER_W-1:0] letter_i,
  output logic [LETTER_W-1:0] inc_letter_o,
  output logic [LETTER_W-1:0] dec_letter_o
);

  localparam logic [LETTER_W-1:0] MAX_L   = LETTER_W'(ALPHA_MAX);
  localparam logic [LETTER_W-1:0] BLANK_L = LETTER_W'(LETTER_BLANK);
  localparam logic [LETTER_W-1:0] FIRST_L = LETTER_W'(LETTER_A);
  localparam logic [LETTER_W-1:0] STEP_L  = LETTER_W'(1);

  // Forward step: blank and the last letter both land on the first letter.
  always_comb begin
    inc_letter_o = FIRST_L;
    if ((letter_i == BLANK_L) || (letter_i >= MAX_L)) begin
      inc_letter_o = FIRST_L;
    end else begin
      inc_letter_o = letter_i + STEP_L;
    end
  end

  // Backward step: blank and the first letter both land on the last letter.
  always_comb begin
    dec_letter_o = MAX_L;
    if ((letter_i == BLANK_L) || (letter_i == FIRST_L) || (letter_i > MAX_L)) begin
      dec_letter_o = MAX_L;
    end else begin
      dec_letter_o = letter_i - STEP_L;
    end
  end

endmodule

// File: rtl/word_entry_stage.sv
// Guess entry: per-column letter editing, cursor, and valid/ready submit of a complete word.
// Optional build macro WORD_ENTRY_LETTER_CARRY_EN: a right move into a blank column copies the letter left behind.
module word_entry_stage
  import wordle_pkg::*;
#(
  parameter int WORD_LEN  = 5,
  parameter int LETTER_W  = 5,
  parameter int ALPHA_MAX = ALPHA_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic                        inc_i,
  input  logic                        dec_i,
  input  logic                        right_i,
  input  logic                        left_i,
  word_entry_stage_if.master          sub_if,
  output logic [$clog2(WORD_LEN)-1:0] cursor_o,
  output logic [LETTER_W-1:0]         cur_letter_o,
  output logic                        reject_o
);

  localparam int                  CW       = $clog2(WORD_LEN);
  localparam logic [CW-1:0]       LAST_COL = CW'(WORD_LEN - 1);
  localparam logic [CW-1:0]       ONE_COL  = CW'(1);
  localparam logic [LETTER_W-1:0] BLANK_L  = LETTER_W'(LETTER_BLANK);

  typedef logic [WORD_LEN-1:0][LETTER_W-1:0] word_t;

  entry_state_t        state_r;
  entry_state_t        state_n_s;
  word_t               letters_r;
  word_t               letters_n_s;
  logic [CW-1:0]       cursor_r;
  logic [CW-1:0]       cursor_n_s;
  logic [LETTER_W-1:0] cur_letter_r;
  logic [LETTER_W-1:0] at_cursor_s;
  logic [LETTER_W-1:0] inc_letter_s;
  logic [LETTER_W-1:0] dec_letter_s;
  logic                valid_r;
  logic                reject_r;
  logic                reject_n_s;
  logic                all_filled_s;

  assign at_cursor_s = letters_r[cursor_r];

  word_entry_stage_letter_cycler #(
    .LETTER_W  (LETTER_W),
    .ALPHA_MAX (ALPHA_MAX)
  ) u_cycler (
    .letter_i     (at_cursor_s),
    .inc_letter_o (inc_letter_s),
    .dec_letter_o (dec_letter_s)
  );

  // A word may only be submitted once no column is blank.
  always_comb begin
    all_filled_s = 1'b1;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (letters_r[i] == BLANK_L) begin
        all_filled_s = 1'b0;
      end else begin
        all_filled_s = all_filled_s;
      end
    end
  end

  // Next-state decode; one edit action per cycle in priority inc > dec > right > left.
  always_comb begin
    state_n_s   = state_r;
    letters_n_s = letters_r;
    cursor_n_s  = cursor_r;
    reject_n_s  = 1'b0;
    case (state_r)
      ST_EDIT: begin
        if (!enable_i) begin
          state_n_s = ST_EDIT;
        end else if (inc_i) begin
          letters_n_s[cursor_r] = inc_letter_s;
        end else if (dec_i) begin
          letters_n_s[cursor_r] = dec_letter_s;
        end else if (right_i) begin
          if (cursor_r != LAST_COL) begin
            cursor_n_s = cursor_r + ONE_COL;
`ifdef WORD_ENTRY_LETTER_CARRY_EN
            if (letters_r[cursor_r + ONE_COL] == BLANK_L) begin
              letters_n_s[cursor_r + ONE_COL] = at_cursor_s;
            end else begin
              letters_n_s = letters_r;
            end
`endif
          end else if (all_filled_s) begin
            state_n_s = ST_SUBMIT;
          end else begin
            reject_n_s = 1'b1;
          end
        end else if (left_i) begin
          if (cursor_r != '0) begin
            cursor_n_s = cursor_r - ONE_COL;
          end else begin
            cursor_n_s = cursor_r;
          end
        end else begin
          state_n_s = ST_EDIT;
        end
      end
      ST_SUBMIT: begin
        // valid is asserted throughout SUBMIT, so ready alone completes the transfer.
        if (sub_if.submit_ready_i) begin
          state_n_s   = ST_EDIT;
          letters_n_s = '0;
          cursor_n_s  = '0;
        end else begin
          state_n_s = ST_SUBMIT;
        end
      end
      default: begin
        state_n_s   = ST_EDIT;
        letters_n_s = '0;
        cursor_n_s  = '0;
      end
    endcase
  end

  // State and all output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_EDIT;
      letters_r    <= '0;
      cursor_r     <= '0;
      cur_letter_r <= '0;
      valid_r      <= 1'b0;
      reject_r     <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      letters_r    <= letters_n_s;
      cursor_r     <= cursor_n_s;
      cur_letter_r <= letters_n_s[cursor_n_s];
      valid_r      <= (state_n_s == ST_SUBMIT);
      reject_r     <= reject_n_s;
    end
  end

  assign sub_if.submit_valid_o = valid_r;
  assign sub_if.word_o         = letters_r;
  assign cursor_o              = cursor_r;
  assign cur_letter_o          = cur_letter_r;
  assign reject_o              = reject_r;

  word_entry_stage_checker #(
    .WORD_LEN  (WORD_LEN),
    .LETTER_W  (LETTER_W),
    .ALPHA_MAX (ALPHA_MAX)
  ) u_checker (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (valid_r),
    .word   (letters_r),
    .cursor (cursor_r)
  );

endmodule

// File: tb/tb_word_entry_stage.sv
// Directed plan items plus randomized pulses, checked against an arithmetic reference model.
module tb_word_entry_stage;

  localparam int WL = 5;
  localparam int LW = 5;
  localparam int AM = 26;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_i = 1'b0;
  logic       inc_i = 1'b0;
  logic       dec_i = 1'b0;
  logic       right_i = 1'b0;
  logic       left_i = 1'b0;
  logic [2:0] cursor_o;
  logic [LW-1:0] cur_letter_o;
  logic       reject_o;

  always #5 clk = ~clk;

  word_entry_stage_if #(.WORD_LEN(WL), .LETTER_W(LW)) sub_if ();

  word_entry_stage #(.WORD_LEN(WL), .LETTER_W(LW), .ALPHA_MAX(AM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .inc_i        (inc_i),
    .dec_i        (dec_i),
    .right_i      (right_i),
    .left_i       (left_i),
    .sub_if       (sub_if),
    .cursor_o     (cursor_o),
    .cur_letter_o (cur_letter_o),
    .reject_o     (reject_o)
  );

  int m_let[WL];
  int m_cur;
  bit m_sub;
  bit m_rej;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(string tag, longint obs, longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic longint model_word();
    longint w = 0;
    for (int i = 0; i < WL; i++) w = w | (longint'(m_let[i]) << (i * LW));
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WL; i++) m_let[i] = 0;
    m_cur = 0; m_sub = 0; m_rej = 0;
  endtask

  task automatic model_step(bit en, bit inc, bit dec, bit r, bit l, bit rdy);
    bit full = 1;
    m_rej = 0;
    if (m_sub) begin
      if (rdy) begin
        for (int i = 0; i < WL; i++) m_let[i] = 0;
        m_cur = 0; m_sub = 0;
      end
    end else if (en) begin
      if (inc) m_let[m_cur] = (m_let[m_cur] % AM) + 1;
      else if (dec) m_let[m_cur] = (m_let[m_cur] == 0) ? AM : ((m_let[m_cur] + AM - 2) % AM) + 1;
      else if (r) begin
        if (m_cur < WL - 1) begin
`ifdef WORD_ENTRY_LETTER_CARRY_EN
          if (m_let[m_cur + 1] == 0) m_let[m_cur + 1] = m_let[m_cur];
`endif
          m_cur++;
        end else begin
          foreach (m_let[i]) if (m_let[i] == 0) full = 0;
          if (full) m_sub = 1; else m_rej = 1;
        end
      end else if (l) begin
        if (m_cur > 0) m_cur--;
      end
    end
  endtask

  task automatic check_all(string tag);
    check_eq({tag, ".cursor"}, cursor_o, m_cur);
    check_eq({tag, ".cur_letter"}, cur_letter_o, m_let[m_cur]);
    check_eq({tag, ".word"}, sub_if.word_o, model_word());
    check_eq({tag, ".valid"}, sub_if.submit_valid_o, m_sub);
    check_eq({tag, ".reject"}, reject_o, m_rej);
  endtask

  task automatic step(string tag, bit en, bit inc, bit dec, bit r, bit l, bit rdy, bit rst = 1'b0);
    enable_i = en; inc_i = inc; dec_i = dec; right_i = r; left_i = l;
    sub_if.submit_ready_i = rdy;
    rst_n = !rst;
    @(posedge clk);
    if (rst) model_reset(); else model_step(en, inc, dec, r, l, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic pulses(string tag, int n, bit inc, bit dec, bit r, bit l);
    for (int i = 0; i < n; i++) step(tag, 1, inc, dec, r, l, 0);
  endtask

  initial begin
    sub_if.submit_ready_i = 1'b0;
    model_reset();
    step("reset", 0, 0, 0, 0, 0, 0, 1);
    check_eq("reset_cursor", cursor_o, 0);
    check_eq("reset_word", sub_if.word_o, 0);
    check_eq("reset_valid", sub_if.submit_valid_o, 0);

    // Three incs at column 0 give C.
    pulses("inc3", 3, 1, 0, 0, 0);
    check_eq("inc3_letter", cur_letter_o, 3);
    check_eq("inc3_word", sub_if.word_o[4:0], 3);

    // Wrap behaviour on a blank column.
    step("rst", 0, 0, 0, 0, 0, 0, 1);
    pulses("dec_blank", 1, 0, 1, 0, 0);
    check_eq("dec_blank_z", cur_letter_o, 26);
    pulses("inc_z", 1, 1, 0, 0, 0);
    check_eq("inc_z_a", cur_letter_o, 1);
    pulses("dec_a", 1, 0, 1, 0, 0);
    check_eq("dec_a_z", cur_letter_o, 26);

    // Fill a word, submit, hold ready low, then accept.
    step("rst", 0, 0, 0, 0, 0, 0, 1);
    pulses("c", 3, 1, 0, 0, 0);   pulses("r0", 1, 0, 0, 1, 0);
    pulses("r", 9, 0, 1, 0, 0);   pulses("r1", 1, 0, 0, 1, 0);
    pulses("a", 1, 1, 0, 0, 0);   pulses("r2", 1, 0, 0, 1, 0);
    pulses("n", 14, 1, 0, 0, 0);  pulses("r3", 1, 0, 0, 1, 0);
    pulses("e", 5, 1, 0, 0, 0);
    pulses("submit", 1, 0, 0, 1, 0);
    check_eq("submit_valid", sub_if.submit_valid_o, 1);
    for (int i = 0; i < 5; i++) step("hold", 1, i[0], 0, 0, !i[0], 0);
    check_eq("hold_valid", sub_if.submit_valid_o, 1);
    step("accept", 1, 0, 0, 0, 0, 1);
    check_eq("accept_word", sub_if.word_o, 0);
    check_eq("accept_cursor", cursor_o, 0);
    check_eq("accept_valid", sub_if.submit_valid_o, 0);

    // Right at the last column with blanks present is rejected.
    pulses("walk", 4, 0, 0, 1, 0);
    pulses("fill4", 1, 1, 0, 0, 0);
    pulses("try", 1, 0, 0, 1, 0);
    check_eq("reject_pulse", reject_o, 1);
    check_eq("reject_valid", sub_if.submit_valid_o, 0);
    step("after_rej", 1, 0, 0, 0, 0, 0);
    check_eq("reject_one_cycle", reject_o, 0);
`ifndef WORD_ENTRY_LETTER_CARRY_EN
    step("rst", 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < WL; c++) begin
      if (c != 2) pulses("fill", 1, 1, 0, 0, 0);
      if (c != WL - 1) pulses("mv", 1, 0, 0, 1, 0);
    end
    pulses("try2", 1, 0, 0, 1, 0);
    check_eq("col2_blank_reject", reject_o, 1);
    check_eq("col2_blank_valid", sub_if.submit_valid_o, 0);
`endif

    // inc wins over right; left at column 0 stays put.
    step("rst", 0, 0, 0, 0, 0, 0, 1);
    pulses("inc_right", 1, 1, 0, 1, 0);
    check_eq("inc_right_letter", cur_letter_o, 1);
    check_eq("inc_right_cursor", cursor_o, 0);
    pulses("left0", 1, 0, 0, 0, 1);
    check_eq("left0_cursor", cursor_o, 0);

    // Carry on right into a blank column.
    step("rst", 0, 0, 0, 0, 0, 0, 1);
    pulses("g", 7, 1, 0, 0, 0);
    pulses("carry", 1, 0, 0, 1, 0);
`ifdef WORD_ENTRY_LETTER_CARRY_EN
    check_eq("carry_col1", sub_if.word_o[9:5], 7);
`else
    check_eq("carry_col1", sub_if.word_o[9:5], 0);
`endif

    // Randomized pulses.
    for (int i = 0; i < 4000; i++) begin
      step("rand", ($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 999) < 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/word_entry_stage.md
Name: word_entry_stage

Overview:
Parametrised successor to the single-letter selection logic. Holds a full guess of WORD_LEN letters, a cursor, and per-column letter editing with wrap-around. It issues a valid/ready submit handshake only when every column is filled. Sits between the button debouncers (pulse inputs) and the game-logic/checker block; word_o also feeds the display driver.

Parameters:
WORD_LEN, 5, number of letter columns (2..8)
LETTER_W, 5, bits per letter code; 0 = blank, 1..ALPHA_MAX = A..
ALPHA_MAX, 26, highest legal letter code (must be < 2**LETTER_W)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable_i  in  1  1 = accept edit pulses; 0 = ignore all edit pulses
inc_i  in  1  one-cycle pulse: next letter at cursor
dec_i  in  1  one-cycle pulse: previous letter at cursor
right_i  in  1  one-cycle pulse: cursor right / submit at last column
left_i  in  1  one-cycle pulse: cursor left
submit_ready_i  in  1  consumer accepts word
submit_valid_o  out  1  word_o is a complete guess awaiting acceptance
word_o  out  WORD_LEN*LETTER_W  column 0 in LSBs
cursor_o  out  $clog2(WORD_LEN)  active column
cur_letter_o  out  LETTER_W  letter at cursor
reject_o  out  1  one-cycle pulse: submit attempted with a blank column

Behaviour:
- Reset (rst_n=0 at a clk edge): all letters 0, cursor_o=0, submit_valid_o=0, reject_o=0, state EDIT. Reset mid-handshake drops valid immediately.
- All outputs registered. Each pulse takes effect on the clk edge where it is sampled, and outputs reflect it in the next cycle.
- States:
  - EDIT: edits accepted when enable_i=1.
  - SUBMIT: submit_valid_o=1 and word_o frozen. All pulses are ignored, including when enable_i=1.
- EDIT priority when several pulses coincide: inc > dec > right > left. Only one action per cycle.
- inc: letter L → L+1. ALPHA_MAX wraps to 1. Blank (0) → 1.
- dec: letter L → L-1. 1 wraps to ALPHA_MAX. Blank (0) → ALPHA_MAX.
- left: cursor-1. At column 0 it is a no-op, with no wrap.
- right, cursor < WORD_LEN-1: cursor+1. The letter in the new column is unchanged.
- right, cursor = WORD_LEN-1:
  - If all columns are nonzero: go to SUBMIT next cycle.
  - Otherwise: reject_o pulses for 1 cycle and the state stays EDIT.
- SUBMIT: hold valid until submit_valid_o && submit_ready_i at a clk edge. On that edge:
  - clear all letters to 0 and set cursor to 0;
  - return to EDIT; valid is 0 next cycle.
  - The transfer count is exactly one per handshake.
- submit_ready_i while in EDIT is ignored.
- Letter values above ALPHA_MAX are unreachable. The checker flags them.

Optional Feature:
WORD_ENTRY_LETTER_CARRY_EN
- Defined: a right move into a blank column loads that column with the letter of the column just left, so repeated letters are quicker to enter.
- Undefined: a right move never modifies letters.
- left never carries, in either build.

Decomposition:
- wordle_pkg holds:
  - LETTER_BLANK=0, LETTER_A=1, ALPHA_MAX_DEF=26 constants;
  - letter_t typedef (logic [4:0]);
  - entry_state_t enum {ST_EDIT, ST_SUBMIT}.
- One natural sub-module, letter_cycler: combinational next-letter function for inc/dec with wrap and blank handling, parametrised on LETTER_W and ALPHA_MAX.

Test Plan:
- Reset, then 3 inc pulses at column 0 → cur_letter_o=3 (C), word_o[4:0]=3, cursor_o=0.
- dec at blank column → 26 (Z); inc at 26 → 1; dec at 1 → 26.
- Fill C,R,A,N,E, then right at column 4 → submit_valid_o=1 next cycle. Hold ready=0 for 5 cycles: valid stays 1, inc/left pulses ignored. ready=1 → all letters 0, cursor 0, valid 0.
- Column 2 left blank, right at column 4 → reject_o one-cycle pulse, submit_valid_o stays 0.
- inc and right on the same cycle → letter incremented, cursor unchanged. left at column 0 → cursor stays 0.
- With WORD_ENTRY_LETTER_CARRY_EN: column 0 = 7, right → column 1 = 7. Without the macro, column 1 stays 0.
